// File: rtl/rr_stream_mux_pkg.sv
// Shared types for the 4-channel round-robin stream merger: channel index, grant-lock states.
// Also holds a one-hot helper used when steering in_ready to the granted channel.
package rr_stream_mux_pkg;

    localparam int N_CH = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic {ARB, HOLD} arb_state_t;

    function automatic logic [N_CH-1:0] ch_onehot(input ch_idx_t c);
        return {{(N_CH-1){1'b0}}, 1'b1} << c;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Round-robin picker: first requesting channel scanning ptr, ptr+1, ... mod 4.
// Purely combinational, zero latency; no handshake of its own.
module rr_pick_4
    import rr_stream_mux_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  ch_idx_t         ptr,
    output ch_idx_t         grant,
    output logic            any
);

    logic [N_CH-1:0] rot;
    ch_idx_t         off;

    // Rotate requests so that bit 0 is the current highest-priority channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            rot[i] = req[ptr + ch_idx_t'(i)];
        end
    end

    always_comb begin
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = ch_idx_t'(i);
        end
    end

    assign grant = ptr + off;
    assign any   = |req;

endmodule

// File: rtl/rr_stream_mux_4.sv
// Four-channel round-robin valid/ready merger. Default: zero-latency pass-through, grant locked while stalled.
// RR_STREAM_MUX_OUT_REG_EN: one-entry output buffer, one-cycle latency, full throughput.
module rr_stream_mux_4
    import rr_stream_mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [N_CH-1:0]  in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output ch_idx_t          out_sel,
    input  logic             out_ready
);

    logic [WIDTH-1:0] data_arr [N_CH];
    ch_idx_t          ptr;
    ch_idx_t          pick_grant;
    ch_idx_t          grant;
    logic             any;
    logic             in_xfer;

    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;

    rr_pick_4 u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .any   (any)
    );

    // Priority rotates past whichever channel just moved an item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (in_xfer) begin
            ptr <= grant + 2'd1;
        end
    end

`ifdef RR_STREAM_MUX_OUT_REG_EN

    logic             full;
    logic             slot_free;
    logic [WIDTH-1:0] buf_dat;
    ch_idx_t          buf_sel;

    assign grant     = pick_grant;
    assign slot_free = !full || out_ready;
    assign in_xfer   = any && slot_free;
    assign in_ready  = in_xfer ? ch_onehot(grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 1'b0;
            buf_dat <= '0;
            buf_sel <= '0;
        end else if (in_xfer) begin
            full    <= 1'b1;
            buf_dat <= data_arr[grant];
            buf_sel <= grant;
        end else if (out_ready) begin
            full    <= 1'b0;
        end
    end

    assign out_valid = full;
    assign out_data  = buf_dat;
    assign out_sel   = buf_sel;

`else

    arb_state_t state;
    arb_state_t state_nxt;
    ch_idx_t    held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (out_valid && !out_ready) state_nxt = HOLD;
            HOLD:    if (in_xfer)                 state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // In HOLD a dropped in_valid[held] is a producer error: show nothing, keep the lock.
    always_comb begin
        grant     = pick_grant;
        out_valid = any;
        if (state == HOLD) begin
            grant     = held;
            out_valid = in_valid[held];
        end
        out_sel  = grant;
        out_data = data_arr[grant];
        in_xfer  = out_valid && out_ready;
        in_ready = in_xfer ? ch_onehot(grant) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (state == ARB && out_valid && !out_ready) begin
            held <= grant;
        end
    end

`endif

endmodule

// File: tb/tb_rr_stream_mux_4.sv
module tb_rr_stream_mux_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [W-1:0] d [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int           m_ptr;
    bit           m_hold;
    int           m_held;
    bit           m_full;
    logic [W-1:0] m_bdat;
    int           m_bsel;
    int           m_g;
    logic [3:0]   e_rdy;
    logic         e_ov;
    logic [W-1:0] e_od;
    int           e_os;

    int           q_sel [$];
    logic [3:0]   pend;

    always #5 clk = ~clk;

    rr_stream_mux_4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (d[0]),
        .in_data1  (d[1]),
        .in_data2  (d[2]),
        .in_data3  (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_hold = 0; m_held = 0; m_full = 0; m_bdat = '0; m_bsel = 0;
    endtask

    task automatic model_eval();
`ifdef RR_STREAM_MUX_OUT_REG_EN
        m_g   = pick(in_valid, m_ptr);
        e_ov  = m_full;
        e_od  = m_bdat;
        e_os  = m_bsel;
        e_rdy = (m_g >= 0 && (!m_full || out_ready)) ? 4'(1 << m_g) : 4'b0;
`else
        if (m_hold) begin
            m_g  = m_held;
            e_ov = in_valid[m_g];
        end else begin
            m_g  = pick(in_valid, m_ptr);
            e_ov = (m_g >= 0);
        end
        e_od  = (m_g >= 0) ? d[m_g] : '0;
        e_os  = m_g;
        e_rdy = (e_ov && out_ready) ? 4'(1 << m_g) : 4'b0;
`endif
    endtask

    task automatic model_update();
`ifdef RR_STREAM_MUX_OUT_REG_EN
        if (e_rdy != 4'b0) begin
            m_bdat = d[m_g];
            m_bsel = m_g;
            m_full = 1;
            m_ptr  = (m_g + 1) % 4;
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
`else
        if (e_ov && out_ready) begin
            m_ptr  = (m_g + 1) % 4;
            m_hold = 0;
        end else if (!m_hold && e_ov) begin
            m_hold = 1;
            m_held = m_g;
        end
`endif
    endtask

    task automatic compare_all(input string tag);
        model_eval();
        chk({tag, "_rdy"}, 32'(in_ready), 32'(e_rdy));
        chk({tag, "_ov"}, 32'(out_valid), 32'(e_ov));
`ifdef RR_STREAM_MUX_OUT_REG_EN
        chk({tag, "_od"}, 32'(out_data), 32'(e_od));
        chk({tag, "_os"}, 32'(out_sel), 32'(e_os));
`else
        if (e_ov) begin
            chk({tag, "_od"}, 32'(out_data), 32'(e_od));
            chk({tag, "_os"}, 32'(out_sel), 32'(e_os));
        end
`endif
    endtask

    // One clock: drive, check between edges, log observed output transfers, advance model.
    task automatic cycle(input string tag, input logic [3:0] v, input logic ordy);
        in_valid  = v;
        out_ready = ordy;
        #1;
        compare_all(tag);
        if (out_valid && out_ready) q_sel.push_back(int'(out_sel));
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        model_reset();
        #12;
        compare_all("reset");
        chk("reset_sel", 32'(out_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cycle("idle", 4'b0000, 1'b1);
        cycle("idle", 4'b0000, 1'b0);

        // Fairness: all four valid, consumer always ready
        d[0] = 4'ha; d[1] = 4'hb; d[2] = 4'hc; d[3] = 4'hd;
        q_sel.delete();
        for (int i = 0; i < 20 && q_sel.size() < 8; i++) cycle("fair", 4'hf, 1'b1);
        chk("fair_count", 32'(q_sel.size() >= 8), 32'd1);
        for (int i = 0; i < 8; i++) chk($sformatf("fair_sel%0d", i), 32'(q_sel[i]), 32'(i % 4));
        cycle("drain", 4'b0000, 1'b1);
        cycle("drain", 4'b0000, 1'b1);

        // Lone channel 2, then channel 1: pointer wraps and channel 1 is still served
        q_sel.delete();
        d[2] = 4'h7;
        cycle("solo2", 4'b0100, 1'b1);
        cycle("solo1", 4'b0010, 1'b1);
        cycle("drain", 4'b0000, 1'b1);
        cycle("drain", 4'b0000, 1'b1);
        chk("solo_count", 32'(q_sel.size()), 32'd2);
        chk("solo_first", 32'(q_sel[0]), 32'd2);
        chk("solo_second", 32'(q_sel[1]), 32'd1);

        // Channel 3 stalled while channel 0 appears
        q_sel.delete();
        cycle("stall", 4'b1000, 1'b0);
        cycle("stall", 4'b1001, 1'b0);
        cycle("stall", 4'b1001, 1'b0);
        chk("stall_sel", 32'(out_sel), 32'd3);
        chk("stall_dat", 32'(out_data), 32'hd);
        cycle("release", 4'b1001, 1'b1);
        cycle("release", 4'b0001, 1'b1);
        cycle("drain", 4'b0000, 1'b1);
        cycle("drain", 4'b0000, 1'b1);
        chk("stall_count", 32'(q_sel.size() >= 2), 32'd1);
        chk("stall_first", 32'(q_sel[0]), 32'd3);
        chk("stall_second", 32'(q_sel[1]), 32'd0);

        // Alternating consumer readiness with all channels busy
        for (int i = 0; i < 16; i++) cycle("toggle", 4'hf, (i % 2) == 0);
        cycle("drain", 4'b0000, 1'b1);
        cycle("drain", 4'b0000, 1'b1);

        // Asynchronous reset while stalled discards the item / lock
        cycle("prerst", 4'b1000, 1'b0);
        cycle("prerst", 4'b1001, 1'b0);
        in_valid = 4'b1001; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
`ifdef RR_STREAM_MUX_OUT_REG_EN
        chk("async_rst_ov", 32'(out_valid), 32'd0);
`else
        chk("async_rst_sel", 32'(out_sel), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q_sel.delete();
        cycle("postrst", 4'b1001, 1'b1);
        cycle("postrst", 4'b1000, 1'b1);
        cycle("drain", 4'b0000, 1'b1);
        cycle("drain", 4'b0000, 1'b1);
        chk("postrst_count", 32'(q_sel.size() >= 1), 32'd1);
        chk("postrst_first", 32'(q_sel[0]), 32'd0);

        // Randomized, protocol-respecting producers: hold valid+data until accepted
        pend = '0;
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && ($urandom % 2 == 1)) begin
                    pend[c] = 1'b1;
                    d[c]    = W'($urandom);
                end
            end
            cycle("rand", pend, ($urandom % 4) != 0);
            pend = pend & ~e_rdy;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
